// File: rtl/halt_tag_lookup_ctrl.sv
// Lookup/refill controller for an 8-way set: halt-tag prefilter, sequential probe, round-robin refill.
// Optional saturating performance counters are enabled with `define CACHE_PERF_CNT_EN.
module halt_tag_lookup_ctrl #(
  parameter int NUM_WAYS = 8,
  parameter int TAG_W    = 24,
  parameter int DATA_W   = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic [4*NUM_WAYS-1:0]   halt_tags,
  input  logic                    set_viv,
  input  logic [TAG_W-5:0]        set_main_tag,
  input  logic [DATA_W-1:0]       set_data,
  output logic [NUM_WAYS-1:0]     way_sel,
  output logic                    set_we,
  output logic [TAG_W-1:0]        set_tag,
  output logic                    set_viv_wr,
  output logic [DATA_W-1:0]       set_wdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [TAG_W-1:0]        mem_req_tag,
  input  logic                    mem_resp_valid,
  input  logic [DATA_W-1:0]       mem_resp_data,
`ifdef CACHE_PERF_CNT_EN
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count,
  output logic [15:0]             probe_count,
`endif
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [2:0]              resp_way,
  output logic [DATA_W-1:0]       resp_data
);

  localparam int IDX_W = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FILL,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [NUM_WAYS-1:0] cand_q, cand_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    way_q, way_d;
  logic                hit_q, hit_d;
  logic [IDX_W-1:0]    victim_q, victim_d;

  logic [NUM_WAYS-1:0] cand_new;
  logic [IDX_W-1:0]    probe_idx;
  logic [NUM_WAYS-1:0] probe_oh;

  // Halt-tag prefilter and lowest-candidate pick; descending loop so the lowest set bit wins.
  always_comb begin
    cand_new  = '0;
    probe_idx = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      cand_new[i] = (halt_tags[4*i +: 4] == req_tag[3:0]);
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (cand_q[i]) probe_idx = IDX_W'(i);
    end
    probe_oh = NUM_WAYS'(1) << probe_idx;
  end

  // NOTE: every signal written here is given a default first, so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    cand_d        = cand_q;
    data_d        = data_q;
    way_d         = way_q;
    hit_d         = hit_q;
    victim_d      = victim_q;
    req_ready     = 1'b0;
    way_sel       = '0;
    set_we        = 1'b0;
    set_tag       = '0;
    set_viv_wr    = 1'b0;
    set_wdata     = '0;
    mem_req_valid = 1'b0;
    mem_req_tag   = '0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_way      = '0;
    resp_data     = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tag_d   = req_tag;
          cand_d  = cand_new;
          state_d = (|cand_new) ? ST_PROBE : ST_MISS_REQ;
        end
      end
      ST_PROBE: begin
        way_sel = probe_oh;
        if (set_viv && set_main_tag == tag_q[TAG_W-1:4]) begin
          data_d  = set_data;
          way_d   = probe_idx;
          hit_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cand_d = cand_q & ~probe_oh;
          if (cand_d == '0) state_d = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_tag   = tag_q;
        if (mem_req_ready) state_d = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (mem_resp_valid) begin
          data_d  = mem_resp_data;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        way_sel    = NUM_WAYS'(1) << victim_q;
        set_we     = 1'b1;
        set_tag    = tag_q;
        set_viv_wr = 1'b1;
        set_wdata  = data_q;
        way_d      = victim_q;
        hit_d      = 1'b0;
        victim_d   = victim_q + IDX_W'(1);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        resp_way   = way_q;
        resp_data  = data_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tag_q    <= '0;
      cand_q   <= '0;
      data_q   <= '0;
      way_q    <= '0;
      hit_q    <= 1'b0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      cand_q   <= cand_d;
      data_q   <= data_d;
      way_q    <= way_d;
      hit_q    <= hit_d;
      victim_q <= victim_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_cnt_q, miss_cnt_q, probe_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      probe_cnt_q <= '0;
    end else begin
      if (state_q == ST_RESP && hit_q && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (state_q == ST_RESP && !hit_q && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
      if (state_q == ST_PROBE && probe_cnt_q != 16'hFFFF)
        probe_cnt_q <= probe_cnt_q + 16'd1;
    end
  end

  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;
  assign probe_count = probe_cnt_q;
`endif

endmodule
